// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller.
// Holds access-size encodings, FSM state enum, wait-counter width and alignment mask.
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        logic [2:0] m;
        unique case (sz)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between a load/store requester and dmem_ctrl.
// master = requester (drives in_*), slave = controller (drives out_*).
interface dmem_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_req;
    logic                  in_wr_en;
    logic [1:0]            in_size;
    logic                  in_unsigned;
    logic [DATA_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  out_busy;
    logic                  out_misaligned;
    logic                  out_fault;

    modport master (
        output in_req, in_wr_en, in_size, in_unsigned, in_addr, in_data,
        input  out_data, out_ready, out_busy, out_misaligned, out_fault
    );

    modport slave (
        input  in_req, in_wr_en, in_size, in_unsigned, in_addr, in_data,
        output out_data, out_ready, out_busy, out_misaligned, out_fault
    );
endinterface

// File: rtl/dmem_align.sv
// dmem_align: combinational lane steering for the data memory.
// Ports: size/unsigned/lane in; store data+byte enables and extended load data out.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0]                      size_i,
    input  logic                            unsigned_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] lane_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic [DATA_WIDTH-1:0]           rword_i,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic [DATA_WIDTH/8-1:0]         be_o,
    output logic [DATA_WIDTH-1:0]           rdata_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [7:0]            bmask;
    logic [DATA_WIDTH-1:0] dmask;
    logic [DATA_WIDTH-1:0] rsh;
    logic                  sign;

    always_comb begin
        bmask = 8'hFF;
        dmask = '1;
        sign  = 1'b0;
        rsh   = rword_i >> {lane_i, 3'b000};
        unique case (size_i)
            SZ_B: begin
                bmask = 8'h01;
                dmask = DATA_WIDTH'(8'hFF);
                sign  = rsh[7];
            end
            SZ_H: begin
                bmask = 8'h03;
                dmask = DATA_WIDTH'(16'hFFFF);
                sign  = rsh[15];
            end
            SZ_W: begin
                bmask = 8'h0F;
                dmask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign  = rsh[31];
            end
            default: ;
        endcase
        wdata_o = (wdata_i & dmask) << {lane_i, 3'b000};
        be_o    = NB'(bmask) << lane_i;
        // Full-width loads need no extension; sign stays 0 for them.
        rdata_o = (rsh & dmask) | ((sign & ~unsigned_i) ? ~dmask : '0);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: clocked data memory with size/extension, error checks and wait states.
// Ports: in_clk, in_rst (async, active-high), bus (dmem_if.slave request/response).
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 1
) (
    input logic   in_clk,
    input logic   in_rst,
    dmem_if.slave bus
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int DEPTH  = (2 ** ADDR_WIDTH) / NB;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, uns_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mis_q, mis_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy, accept;
    logic                  fault_c, mis_c, err_c, commit;
    logic                  cur_wr, cur_uns;
    logic [1:0]            cur_size;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DATA_WIDTH-1:0] wdata_sh, rdata_ext, rword;
    logic [NB-1:0]         be;

    assign busy   = (state_q == WAIT);
    assign accept = bus.in_req & ~busy;

    assign fault_c = (|(bus.in_addr >> ADDR_WIDTH))
                   | ((bus.in_size == SZ_D) && (DATA_WIDTH == 32));
    assign mis_c   = |(bus.in_addr[2:0] & align_mask(bus.in_size));
    assign err_c   = fault_c | mis_c;

    // Zero-wait accesses commit on the acceptance edge straight from the bus;
    // otherwise the latched request is used when WAIT expires.
    assign cur_wr   = accept ? bus.in_wr_en : wr_q;
    assign cur_uns  = accept ? bus.in_unsigned : uns_q;
    assign cur_size = accept ? bus.in_size : size_q;
    assign cur_addr = accept ? bus.in_addr[ADDR_WIDTH-1:0] : addr_q;
    assign cur_data = accept ? bus.in_data : data_q;

    assign commit = (accept && !err_c && (WAIT_CYCLES == 0))
                  || ((state_q == WAIT) && (cnt_q == '0));

    assign rword = mem[cur_addr[ADDR_WIDTH-1:LANE_W]];

    dmem_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .size_i     (cur_size),
        .unsigned_i (cur_uns),
        .lane_i     (cur_addr[LANE_W-1:0]),
        .wdata_i    (cur_data),
        .rword_i    (rword),
        .wdata_o    (wdata_sh),
        .be_o       (be),
        .rdata_o    (rdata_ext)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (err_c || (WAIT_CYCLES == 0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        if (accept && err_c) begin
            rdata_d = '0;
            mis_d   = mis_c & ~fault_c;
            fault_d = fault_c;
        end else if (commit) begin
            rdata_d = cur_wr ? '0 : rdata_ext;
            mis_d   = 1'b0;
            fault_d = 1'b0;
        end
    end

    assign bus.out_data       = rdata_q;
    assign bus.out_ready      = (state_q == DONE);
    assign bus.out_busy       = busy;
    assign bus.out_misaligned = mis_q;
    assign bus.out_fault      = fault_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_q   <= bus.in_wr_en;
                uns_q  <= bus.in_unsigned;
                size_q <= bus.in_size;
                addr_q <= bus.in_addr[ADDR_WIDTH-1:0];
                data_q <= bus.in_data;
            end
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    // Storage is never reset; reset only has to block a pending commit.
    always_ff @(posedge in_clk) begin
        if (commit && cur_wr && !in_rst) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[cur_addr[ADDR_WIDTH-1:LANE_W]][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

endmodule
